// File: rtl/token_encoder.sv
// token_encoder: greedy vocabulary tokenizer.
// Buffers one word of symbols, then repeatedly scans a writable vocabulary
// (one symbol compare per cycle) and emits the best token ID per position.
// Unmatched positions emit UNK_ID and advance by one symbol.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the first symbol of a word; vocabulary writable
// LOAD  | storing further symbols of the word into the word buffer
// SCAN  | walking vocabulary entries against the word at pos
// EMIT  | presenting the selected token until out_ready
// DONE  | one-cycle completion pulse, then back to IDLE
module token_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TOKENS = 16,
  parameter int MAX_LEN    = 4,
  parameter int WORD_DEPTH = 16,
  parameter int UNK_ID     = NUM_TOKENS - 1,
  parameter int ID_W       = $clog2(NUM_TOKENS),
  parameter int VA_W       = $clog2(NUM_TOKENS * MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vocab_we,
  input  logic [VA_W-1:0]       vocab_addr,
  input  logic [DATA_WIDTH-1:0] vocab_din,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // Word length and position need to reach WORD_DEPTH itself.
  localparam int POS_W = $clog2(WORD_DEPTH + 1);
  localparam int PW1   = POS_W + 1;
  localparam int WA_W  = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  // Entry length / compare index needs to reach MAX_LEN itself.
  localparam int K_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] vocab_mem [NUM_TOKENS*MAX_LEN];
  logic [DATA_WIDTH-1:0] word_mem  [WORD_DEPTH];

  logic [POS_W-1:0] word_len_q;
  logic [POS_W-1:0] pos_q;
  logic             mode_q;
  logic             overflow_q;

  logic [ID_W-1:0]  t_q;
  logic [K_W-1:0]   k_q;
  logic [ID_W-1:0]  best_id_q;
  logic [K_W-1:0]   best_len_q;
  logic [K_W-1:0]   adv_q;
  logic [ID_W-1:0]  out_id_q;
  logic             out_last_q;

  // Load-side signals
  logic             accept;
  logic [POS_W-1:0] wr_idx;
  logic             depth_hit;
  logic             load_end;

  // Scan-side signals
  logic [PW1-1:0]        probe;
  logic                  probe_in;
  logic [VA_W-1:0]       vidx;
  logic [DATA_WIDTH-1:0] vsym;
  logic [DATA_WIDTH-1:0] wsym;
  logic                  term;
  logic                  sym_ok;
  logic                  last_k;
  logic                  entry_end;
  logic                  entry_hit;
  logic [K_W-1:0]        hit_len;
  logic                  take;
  logic                  scan_done;
  logic [ID_W-1:0]       res_id;
  logic [K_W-1:0]        res_len;
  logic [K_W-1:0]        adv;
  logic                  res_last;

  // Load addressing: the first symbol of a word always lands at address 0.
  always_comb begin
    accept    = in_valid && in_ready;
    wr_idx    = (state_q == S_IDLE) ? '0 : word_len_q;
    depth_hit = (wr_idx == POS_W'(WORD_DEPTH - 1));
    load_end  = in_last || depth_hit;
  end

  // One compare step of the vocabulary walk plus best-match selection.
  always_comb begin
    probe    = {1'b0, pos_q} + PW1'(k_q);
    probe_in = (probe < {1'b0, word_len_q});
    vidx     = VA_W'(int'(t_q) * MAX_LEN + int'(k_q));
    vsym     = vocab_mem[vidx];
    wsym     = word_mem[probe[WA_W-1:0]];

    term      = (vsym == '0);
    sym_ok    = !term && probe_in && (wsym == vsym);
    last_k    = (k_q == K_W'(MAX_LEN - 1));
    entry_end = term || !sym_ok || last_k;

    // A terminator after k matched symbols means the whole entry matched.
    hit_len   = term ? k_q : K_W'(MAX_LEN);
    entry_hit = entry_end && (t_q != ID_W'(UNK_ID)) &&
                ((term && (k_q != '0)) || (sym_ok && last_k));

    // Strictly longer wins, so ties stay with the lower index.
    take      = entry_hit && (hit_len > best_len_q);
    scan_done = entry_end && ((t_q == ID_W'(NUM_TOKENS - 1)) || (mode_q && entry_hit));

    res_id  = best_id_q;
    res_len = best_len_q;
    if (take) begin
      res_id  = t_q;
      res_len = hit_len;
    end
    adv = res_len;
    if (res_len == '0) begin
      res_id = ID_W'(UNK_ID);
      adv    = K_W'(1);
    end
    res_last = (({1'b0, pos_q} + PW1'(adv)) >= {1'b0, word_len_q});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = load_end ? S_SCAN : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_end) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = out_last_q ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vocabulary, word buffer, scan walker and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TOKENS * MAX_LEN; i++) vocab_mem[i] <= '0;
      for (int i = 0; i < WORD_DEPTH; i++) word_mem[i] <= '0;
      word_len_q <= '0;
      pos_q      <= '0;
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
      t_q        <= '0;
      k_q        <= '0;
      best_id_q  <= '0;
      best_len_q <= '0;
      adv_q      <= '0;
      out_id_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (vocab_we && (state_q == S_IDLE)) vocab_mem[vidx_w(vocab_addr)] <= vocab_din;

      if (accept) begin
        word_mem[wr_idx[WA_W-1:0]] <= in_data;
        word_len_q                 <= wr_idx + POS_W'(1);
        if (state_q == S_IDLE) mode_q <= mode;
        // Truncation only when the buffer fills without a real end of word.
        if (depth_hit && !in_last) overflow_q <= 1'b1;
        else if (state_q == S_IDLE) overflow_q <= 1'b0;
      end

      if (state_q == S_SCAN) begin
        if (entry_end) begin
          t_q <= t_q + ID_W'(1);
          k_q <= '0;
          if (take) begin
            best_id_q  <= t_q;
            best_len_q <= hit_len;
          end
        end else begin
          k_q <= k_q + K_W'(1);
        end
        if (scan_done) begin
          out_id_q   <= res_id;
          out_last_q <= res_last;
          adv_q      <= adv;
        end
      end else begin
        t_q        <= '0;
        k_q        <= '0;
        best_id_q  <= '0;
        best_len_q <= '0;
      end

      if ((state_q == S_EMIT) && out_ready) pos_q <= pos_q + POS_W'(adv_q);
      if (state_q == S_DONE) pos_q <= '0;
    end
  end

  // Identity helper keeps the write port index at the array's address width.
  function automatic logic [VA_W-1:0] vidx_w(input logic [VA_W-1:0] a);
    return a;
  endfunction

  assign out_id   = out_id_q;
  assign out_last = out_last_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_token_encoder.sv
// Directed bench for token_encoder with hand-computed token sequences.
module tb_token_encoder;
  localparam int DW   = 8;
  localparam int NT   = 16;
  localparam int ML   = 4;
  localparam int WD   = 16;
  localparam int ID_W = 4;
  localparam int VA_W = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            vocab_we;
  logic [VA_W-1:0] vocab_addr;
  logic [DW-1:0]   vocab_din;
  logic            mode;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  token_encoder #(
    .DATA_WIDTH(DW), .NUM_TOKENS(NT), .MAX_LEN(ML), .WORD_DEPTH(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .vocab_we(vocab_we), .vocab_addr(vocab_addr), .vocab_din(vocab_din),
    .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic write_entry(input int e, input string s);
    for (int k = 0; k < ML; k++) begin
      vocab_we   = 1'b1;
      vocab_addr = VA_W'(e * ML + k);
      vocab_din  = (k < s.len()) ? s[k] : 8'h00;
      @(negedge clk);
    end
    vocab_we = 1'b0;
  endtask

  task automatic send_word(input string w, input logic m);
    for (int i = 0; i < w.len(); i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == w.len() - 1);
      mode     = m;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int budget;
    budget = 0;
    while (!out_valid && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!out_valid) check_eq({tag, " wait timeout"}, 0, 1);
  endtask

  task automatic expect_tokens(input string tag);
    int n;
    int budget;
    n = exp_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      while (!out_valid && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      if (!out_valid) begin
        check_eq({tag, " timeout"}, 0, 1);
        exp_q.delete();
        return;
      end
      check_eq($sformatf("%s id%0d", tag, i), out_id, exp_q[i]);
      check_eq($sformatf("%s last%0d", tag, i), out_last, (i == n - 1));
      @(negedge clk);
    end
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " no extra"}, out_valid, 0);
    @(negedge clk);
    check_eq({tag, " done pulse"}, done, 0);
    check_eq({tag, " idle ready"}, in_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    int acc;
    rst        = 1'b1;
    vocab_we   = 1'b0;
    vocab_addr = '0;
    vocab_din  = '0;
    mode       = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_eq("rst in_ready", in_ready, 1);
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst out_id", out_id, 0);
    check_eq("rst out_last", out_last, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst overflow", overflow, 0);

    write_entry(0, "ab");
    write_entry(1, "abc");
    write_entry(2, "c");
    write_entry(3, "b");

    // Longest match: "abc" then "b".
    send_word("abcb", 1'b0);
    check_eq("lm busy", busy, 1);
    check_eq("lm in_ready", in_ready, 0);
    exp_q.push_back(1); exp_q.push_back(3);
    expect_tokens("lm");

    // First match: "ab", "c", "b".
    send_word("abcb", 1'b1);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    expect_tokens("fm");

    // Backpressure on the first token.
    out_ready = 1'b0;
    send_word("abcb", 1'b0);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check_eq("stall valid", out_valid, 1);
      check_eq("stall id", out_id, 1);
      @(negedge clk);
    end
    exp_q.push_back(1); exp_q.push_back(3);
    expect_tokens("stall");

    // Buffer overflow: 18 symbols offered, no in_last; "abab..." -> 8 x "ab".
    acc = 0;
    for (int i = 0; i < WD + 2; i++) begin
      in_valid = 1'b1;
      in_data  = (i % 2 == 0) ? 8'h61 : 8'h62;
      in_last  = 1'b0;
      mode     = 1'b0;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("ovf accepted", acc, WD);
    check_eq("ovf ready low", in_ready, 0);
    check_eq("ovf flag", overflow, 1);
    for (int i = 0; i < WD / 2; i++) exp_q.push_back(0);
    expect_tokens("ovf");
    check_eq("ovf sticky", overflow, 1);

    // Unknown symbol then "ab"; new word clears overflow.
    send_word("xab", 1'b0);
    check_eq("xab ovf clear", overflow, 0);
    exp_q.push_back(15); exp_q.push_back(0);
    expect_tokens("xab");

    // Reset during EMIT drops the token and clears the vocabulary.
    out_ready = 1'b0;
    send_word("abcb", 1'b0);
    wait_valid("rst emit");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst emit valid", out_valid, 0);
    check_eq("rst emit busy", busy, 0);
    check_eq("rst emit id", out_id, 0);

    // "b" was entry 3 before reset; now it must be unknown.
    send_word("b", 1'b0);
    check_eq("busy write busy", busy, 1);
    vocab_we   = 1'b1;
    vocab_addr = '0;
    vocab_din  = 8'h62;
    @(negedge clk);
    vocab_we = 1'b0;
    exp_q.push_back(15);
    expect_tokens("zero vocab");

    // The write issued while busy must not have landed.
    send_word("b", 1'b0);
    exp_q.push_back(15);
    expect_tokens("busy write");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
